// File: rtl/if_stage_if.sv
// Handshake bundle of the instruction-fetch stage: PC generator, instruction
// memory and IF/ID slot. The master side is the fetch stage itself.
interface if_stage_if #(
    parameter int XLEN = 32
);
    logic            pc_adv_o;
    logic [XLEN-1:0] pc_i;
    logic            flush_i;

    logic            imem_req_valid_o;
    logic            imem_req_ready_i;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_rsp_valid_i;
    logic [XLEN-1:0] imem_rsp_data_i;

    logic            id_valid_o;
    logic            id_ready_i;
    logic [XLEN-1:0] id_pc_o;
    logic [XLEN-1:0] id_instr_o;

    modport master (
        input  pc_i, flush_i,
        input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
        input  id_ready_i,
        output pc_adv_o,
        output imem_req_valid_o, imem_addr_o,
        output id_valid_o, id_pc_o, id_instr_o
    );

    modport slave (
        output pc_i, flush_i,
        output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
        output id_ready_i,
        input  pc_adv_o,
        input  imem_req_valid_o, imem_addr_o,
        input  id_valid_o, id_pc_o, id_instr_o
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: single-outstanding memory request, one-entry hold
// buffer for responses arriving under decode stall, and an IF/ID output slot.
module if_stage #(
    parameter int XLEN = 32
) (
    input logic             clk,
    input logic             reset,
    if_stage_if.master      bus
);
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        DRAIN
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pend_pc;
    logic [XLEN-1:0] hold_pc;
    logic [XLEN-1:0] hold_instr;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_instr;

    logic            req_valid;
    logic            req_fire;
    logic            slot_free;

    // Request side is combinational so the PC generator can advance in the
    // same cycle the memory accepts its PC.
    assign req_valid = (state == REQ) && !bus.flush_i && !reset;
    assign req_fire  = req_valid && bus.imem_req_ready_i;
    assign slot_free = !id_valid || bus.id_ready_i;

    assign bus.imem_req_valid_o = req_valid;
    assign bus.imem_addr_o      = bus.pc_i;
    assign bus.pc_adv_o         = req_fire;
    assign bus.id_valid_o       = id_valid;
    assign bus.id_pc_o          = id_pc;
    assign bus.id_instr_o       = id_instr;

    // NOTE: every register here, including the hold buffer, is in the reset
    // list; it is a handful of flops, not a RAM, so clearing it costs nothing
    // and keeps the outputs deterministic after a mid-operation reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= REQ;
            pend_pc    <= '0;
            hold_pc    <= '0;
            hold_instr <= '0;
            id_valid   <= 1'b0;
            id_pc      <= '0;
            id_instr   <= NOP;
        end else if (bus.flush_i) begin
            id_valid   <= 1'b0;
            hold_pc    <= '0;
            hold_instr <= '0;
            unique case (state)
                REQ, HOLD: state <= REQ;
                WAIT:      state <= bus.imem_rsp_valid_i ? REQ : DRAIN;
                DRAIN:     state <= bus.imem_rsp_valid_i ? REQ : DRAIN;
                default:   state <= REQ;
            endcase
        end else begin
            // NOTE: non-blocking assignments throughout; the slot-load branches
            // below override this default consumption within the same edge.
            if (id_valid && bus.id_ready_i) begin
                id_valid <= 1'b0;
            end

            unique case (state)
                REQ: begin
                    if (req_fire) begin
                        pend_pc <= bus.pc_i;
                        state   <= WAIT;
                    end
                end

                WAIT: begin
                    if (bus.imem_rsp_valid_i) begin
                        if (slot_free) begin
                            id_valid <= 1'b1;
                            id_pc    <= pend_pc;
                            id_instr <= bus.imem_rsp_data_i;
                        end else begin
                            hold_pc    <= pend_pc;
                            hold_instr <= bus.imem_rsp_data_i;
                        end
                        state <= slot_free ? REQ : HOLD;
                    end
                end

                HOLD: begin
                    if (slot_free) begin
                        id_valid <= 1'b1;
                        id_pc    <= hold_pc;
                        id_instr <= hold_instr;
                        state    <= REQ;
                    end
                end

                DRAIN: begin
                    // Response to a request killed by an earlier flush.
                    if (bus.imem_rsp_valid_i) begin
                        state <= REQ;
                    end
                end

                default: state <= REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed stimulus pushes expected (pc, instr)
// pairs; a negedge monitor pops them whenever decode consumes the slot.
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset;

    if_stage_if #(.XLEN(32)) bus ();

    if_stage #(.XLEN(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   adv_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pair(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        if (bus.pc_adv_o) adv_cnt++;
    end

    // Monitor: checks every consumed slot against the scoreboard.
    always @(negedge clk) begin
        if (!reset && bus.id_valid_o) begin
            check("no_stale_instr", 32'(bus.id_instr_o == 32'hDEAD), 32'd0);
            if (bus.id_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_delivery_pc", bus.id_pc_o, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("delivered_pc", bus.id_pc_o, e.pc);
                    check("delivered_instr", bus.id_instr_o, e.instr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int adv_start;

        reset                = 1'b1;
        bus.pc_i             = '0;
        bus.flush_i          = 1'b0;
        bus.imem_req_ready_i = 1'b0;
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_rsp_data_i  = '0;
        bus.id_ready_i       = 1'b1;
        #2;
        check("reset_id_instr", bus.id_instr_o, NOP);
        check("reset_id_valid", 32'(bus.id_valid_o), 32'd0);
        check("reset_req_valid", 32'(bus.imem_req_valid_o), 32'd0);
        check("reset_pc_adv", 32'(bus.pc_adv_o), 32'd0);
        repeat (2) cyc();
        reset = 1'b0;

        // Free run, zero-wait memory, decode always ready.
        adv_start = adv_cnt;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] pc;
            pc = 32'(i * 4);
            bus.pc_i             = pc;
            bus.imem_req_ready_i = 1'b1;
            bus.imem_rsp_valid_i = 1'b0;
            #1;
            check("run_pc_adv", 32'(bus.pc_adv_o), 32'd1);
            check("run_addr", bus.imem_addr_o, pc);
            check("run_slot_before", 32'(bus.id_valid_o), (i > 0) ? 32'd1 : 32'd0);
            expect_pair(pc, 32'hA0 + pc);
            cyc();
            check("run_slot_consumed", 32'(bus.id_valid_o), 32'd0);
            bus.pc_i             = pc + 32'd4;
            bus.imem_rsp_valid_i = 1'b1;
            bus.imem_rsp_data_i  = 32'hA0 + pc;
            #1;
            check("run_no_adv_in_wait", 32'(bus.pc_adv_o), 32'd0);
            cyc();
        end
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_req_ready_i = 1'b0;
        repeat (2) cyc();
        check("run_adv_count", 32'(adv_cnt - adv_start), 32'd3);

        // Memory wait: request stalls 3 cycles, response 4 cycles late.
        bus.pc_i = 32'h40;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("wait_req_valid", 32'(bus.imem_req_valid_o), 32'd1);
            check("wait_addr_held", bus.imem_addr_o, 32'h40);
            check("wait_no_adv", 32'(bus.pc_adv_o), 32'd0);
            cyc();
        end
        bus.imem_req_ready_i = 1'b1;
        #1;
        check("wait_accept_adv", 32'(bus.pc_adv_o), 32'd1);
        expect_pair(32'h40, 32'hE0);
        cyc();
        bus.imem_req_ready_i = 1'b0;
        bus.pc_i             = 32'h44;
        repeat (4) cyc();
        bus.imem_rsp_valid_i = 1'b1;
        bus.imem_rsp_data_i  = 32'hE0;
        #1;
        check("wait_valid_before_rsp_edge", 32'(bus.id_valid_o), 32'd0);
        cyc();
        bus.imem_rsp_valid_i = 1'b0;
        check("wait_valid_after_rsp", 32'(bus.id_valid_o), 32'd1);
        cyc();

        // Decode stall: pc 0 in slot, pc 4 in hold, no third request.
        bus.id_ready_i       = 1'b0;
        bus.pc_i             = 32'h0;
        bus.imem_req_ready_i = 1'b1;
        expect_pair(32'h0, 32'hA0);
        cyc();
        bus.pc_i             = 32'h4;
        bus.imem_rsp_valid_i = 1'b1;
        bus.imem_rsp_data_i  = 32'hA0;
        cyc();
        bus.imem_rsp_valid_i = 1'b0;
        expect_pair(32'h4, 32'hA4);
        cyc();
        bus.pc_i             = 32'h8;
        bus.imem_rsp_valid_i = 1'b1;
        bus.imem_rsp_data_i  = 32'hA4;
        cyc();
        bus.imem_rsp_valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("stall_slot_valid", 32'(bus.id_valid_o), 32'd1);
            check("stall_slot_pc", bus.id_pc_o, 32'h0);
            check("stall_no_third_req", 32'(bus.imem_req_valid_o), 32'd0);
            cyc();
        end
        bus.imem_req_ready_i = 1'b0;
        bus.id_ready_i       = 1'b1;
        cyc();
        check("stall_hold_to_slot", bus.id_pc_o, 32'h4);
        repeat (2) cyc();

        // Flush while waiting; stale 0xDEAD response arrives two cycles later.
        bus.pc_i             = 32'h80;
        bus.imem_req_ready_i = 1'b1;
        cyc();
        bus.imem_req_ready_i = 1'b0;
        bus.flush_i          = 1'b1;
        #1;
        check("flush_no_req", 32'(bus.imem_req_valid_o), 32'd0);
        check("flush_no_adv", 32'(bus.pc_adv_o), 32'd0);
        cyc();
        bus.flush_i = 1'b0;
        bus.imem_req_ready_i = 1'b1;
        #1;
        check("drain_no_req", 32'(bus.imem_req_valid_o), 32'd0);
        cyc();
        bus.imem_req_ready_i = 1'b0;
        bus.imem_rsp_valid_i = 1'b1;
        bus.imem_rsp_data_i  = 32'hDEAD;
        cyc();
        bus.imem_rsp_valid_i = 1'b0;
        check("drain_slot_empty", 32'(bus.id_valid_o), 32'd0);
        bus.pc_i             = 32'h100;
        bus.imem_req_ready_i = 1'b1;
        #1;
        check("redirect_adv", 32'(bus.pc_adv_o), 32'd1);
        expect_pair(32'h100, 32'h1A0);
        cyc();
        bus.imem_req_ready_i = 1'b0;
        bus.imem_rsp_valid_i = 1'b1;
        bus.imem_rsp_data_i  = 32'h1A0;
        cyc();
        bus.imem_rsp_valid_i = 1'b0;
        check("redirect_pc", bus.id_pc_o, 32'h100);
        cyc();

        // Flush in HOLD with a full slot: both entries dropped.
        bus.id_ready_i       = 1'b0;
        bus.pc_i             = 32'h200;
        bus.imem_req_ready_i = 1'b1;
        cyc();
        bus.imem_req_ready_i = 1'b0;
        bus.pc_i             = 32'h204;
        bus.imem_rsp_valid_i = 1'b1;
        bus.imem_rsp_data_i  = 32'h2A0;
        cyc();
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_req_ready_i = 1'b1;
        cyc();
        bus.imem_req_ready_i = 1'b0;
        bus.imem_rsp_valid_i = 1'b1;
        bus.imem_rsp_data_i  = 32'h2A4;
        cyc();
        bus.imem_rsp_valid_i = 1'b0;
        #1;
        check("hold_slot_pc", bus.id_pc_o, 32'h200);
        check("hold_no_req", 32'(bus.imem_req_valid_o), 32'd0);
        bus.flush_i = 1'b1;
        cyc();
        bus.flush_i          = 1'b0;
        bus.pc_i             = 32'h300;
        bus.imem_req_ready_i = 1'b1;
        bus.id_ready_i       = 1'b1;
        #1;
        check("hold_flush_slot_cleared", 32'(bus.id_valid_o), 32'd0);
        check("hold_flush_req_next", 32'(bus.imem_req_valid_o), 32'd1);
        check("hold_flush_adv", 32'(bus.pc_adv_o), 32'd1);
        expect_pair(32'h300, 32'h3A0);
        cyc();
        bus.imem_req_ready_i = 1'b0;
        bus.imem_rsp_valid_i = 1'b1;
        bus.imem_rsp_data_i  = 32'h3A0;
        cyc();
        bus.imem_rsp_valid_i = 1'b0;
        cyc();

        // Mid-operation reset while a response is outstanding.
        bus.pc_i             = 32'h400;
        bus.imem_req_ready_i = 1'b1;
        cyc();
        bus.imem_req_ready_i = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_instr", bus.id_instr_o, NOP);
        check("async_reset_pc", bus.id_pc_o, 32'h0);
        check("async_reset_valid", 32'(bus.id_valid_o), 32'd0);
        check("async_reset_req", 32'(bus.imem_req_valid_o), 32'd0);
        cyc();
        reset                = 1'b0;
        bus.pc_i             = 32'h0;
        bus.imem_req_ready_i = 1'b1;
        #1;
        check("restart_req", 32'(bus.imem_req_valid_o), 32'd1);
        check("restart_adv", 32'(bus.pc_adv_o), 32'd1);
        check("restart_addr", bus.imem_addr_o, 32'h0);
        expect_pair(32'h0, 32'hA0);
        cyc();
        bus.imem_req_ready_i = 1'b0;
        bus.imem_rsp_valid_i = 1'b1;
        bus.imem_rsp_data_i  = 32'hA0;
        cyc();
        bus.imem_rsp_valid_i = 1'b0;
        repeat (3) cyc();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage between the PC generator and decode. Each cycle the PC generator presents `pc_i`. This block:
- issues a single-outstanding request to instruction memory;
- pulses `pc_adv_o` so the PC generator advances only when its PC was accepted;
- registers the returned instruction with its PC into an IF/ID output slot under a valid/ready handshake.

A one-entry hold buffer absorbs responses that arrive while decode is stalled. `flush_i` discards everything in flight so a redirected PC can be fetched cleanly.

## Interface
- XLEN, 32, address/data width
- NOP, 32'h0000_0013, value driven on `id_instr_o` at reset (addi x0,x0,0)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- pc_i  in  XLEN  current PC from PC generator
- pc_adv_o  out  1  1-cycle pulse: `pc_i` accepted, PC generator must update its PC this edge
- flush_i  in  1  redirect/kill: drop all fetched and in-flight instructions
- imem_req_valid_o  out  1  fetch request valid
- imem_req_ready_i  in  1  memory accepts request
- imem_addr_o  out  XLEN  request address = `pc_i`
- imem_rsp_valid_i  in  1  response valid (no backpressure, one per accepted request)
- imem_rsp_data_i  in  XLEN  instruction word
- id_valid_o  out  1  IF/ID slot holds a valid instruction
- id_ready_i  in  1  decode consumes slot this cycle
- id_pc_o  out  XLEN  PC of slot instruction
- id_instr_o  out  XLEN  slot instruction

## Operation
- **States:** REQ, WAIT, HOLD, DRAIN. The reset state is REQ.
- **Slot-free condition:** `slot_free = !id_valid_o || id_ready_i`.
- **REQ**
  - `imem_req_valid_o = !flush_i` (the output is 0 while `reset` is high); `imem_addr_o = pc_i`.
  - When `imem_req_valid_o && imem_req_ready_i`:
    - `pc_adv_o` = 1;
    - `pc_i` is latched into `pend_pc`;
    - next state is WAIT.
  - `imem_rsp_valid_i` is ignored in REQ.
- **WAIT:** handles `imem_rsp_valid_i`.
  - If `slot_free`: load `{pend_pc, rsp_data}` into the slot, set `id_valid_o` = 1, next state REQ.
  - Otherwise: load the response into the hold buffer, next state HOLD.
- **HOLD:** when `slot_free`, move the hold buffer into the slot, set `id_valid_o` = 1, next state REQ.
- **DRAIN:** the next `imem_rsp_valid_i` is discarded, next state REQ.
- **Slot consumption:** when `id_valid_o && id_ready_i` and nothing is loaded that cycle, `id_valid_o` goes to 0 at the next edge.
- **`flush_i` (highest priority, any state)**
  - `id_valid_o` goes to 0 next edge and the hold buffer is cleared.
  - No request is issued in the flush cycle and `pc_adv_o` = 0.
  - Next-state rules:
    - from REQ or HOLD, next state is REQ;
    - from WAIT, next state is DRAIN; if `imem_rsp_valid_i` is high in the same cycle, that response is discarded and the next state is REQ instead;
    - in DRAIN, the state stays DRAIN unless `rsp_valid` is high, then REQ.
- **Ordering:** PCs delivered to decode are strictly in request order; no instruction is lost or duplicated without a flush.
- **Reset values:**
  - all outputs 0 except `id_instr_o` = NOP;
  - `pend_pc` and the hold buffer are 0;
  - state is REQ.
  - A mid-operation reset returns the block to REQ immediately and abandons any outstanding response. Memory must be reset together with this block.

## Timing
- Request acceptance at edge N produces a `pc_adv_o` pulse in cycle N, so the new PC is visible at N+1.
- The earliest legal response is in cycle N+1. A response in cycle M with `slot_free` gives `id_valid_o` = 1 from M+1.
- The next request can issue in cycle M+1. Peak throughput is therefore 1 instruction per 2 cycles at zero memory wait.
- **Decode stall:** a response arriving while decode is stalled goes to HOLD. It is visible at decode one cycle after `slot_free`.
- **Combinational paths:**
  - `pc_adv_o` and `imem_req_valid_o` depend on `imem_req_ready_i` and `flush_i`;
  - `id_*` outputs are registered only.

## Test plan
- **Reset then free run:** reset, `pc_i` stepping 0, 4, 8; memory ready=1, 1-cycle response `instr = 0xA0+pc`; `id_ready_i` = 1.
  - Required: after reset, `id_instr_o` = 0x00000013 and `id_valid_o` = 0.
  - Required: decode receives (0,0xA0), (4,0xA4), (8,0xA8) on alternating cycles.
  - Required: `pc_adv_o` pulses once per request.
- **Memory wait:** `imem_req_ready_i` low 3 cycles, then response delayed 4 cycles.
  - Required: `imem_addr_o` is held and `pc_adv_o` stays 0 until acceptance.
  - Required: `id_valid_o` rises 1 cycle after `rsp_valid`.
- **Decode stall:** with `id_ready_i` = 0, two fetches arrive (pc 0 and 4).
  - Required: the slot holds pc 0, pc 4 is in HOLD, and no third request is issued.
  - Required: after `id_ready_i` = 1, decode sees pc 0 then pc 4.
- **Flush while waiting:** flush in WAIT, stale response (0xDEAD) 2 cycles later, then `pc_i` = 0x100.
  - Required: 0xDEAD is never presented on the `id_*` outputs.
  - Required: the next delivered instruction has `id_pc_o` = 0x100.
- **Flush during HOLD with a full slot:**
  - Required: `id_valid_o` = 0 next cycle and the hold contents are dropped.
  - Required: a request is issued the cycle after the flush.
- **Mid-operation reset:** assert reset in WAIT.
  - Required: all outputs return to reset values asynchronously.
  - Required: fetch restarts from `pc_i` = 0 in state REQ.
